// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: request/result bundle between a binary source and the
// bin2bcd_seq converter.
//   start    : source -> converter, request a conversion of bin_in
//   bin_in   : source -> converter, binary value (BIN_W bits)
//   busy     : converter -> source, conversion in progress
//   done     : converter -> source, one-cycle result-valid pulse
//   ovf      : converter -> source, last accepted value was out of range
//   dsp_data : converter -> source, packed BCD word, MSD in the top nibble
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 27,
  parameter int DIGITS = 8
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic                  ovf;
  logic [4*DIGITS-1:0]   dsp_data;

  modport master (
    output start, bin_in,
    input  busy, done, ovf, dsp_data
  );

  modport slave (
    input  start, bin_in,
    output busy, done, ovf, dsp_data
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary to packed-BCD converter (double dabble)
// feeding the multiplexed seven-segment driver.
//   bcd_clk : clock, all logic on the rising edge
//   bcd_rst : synchronous active-low reset
//   bus     : bin2bcd_seq_if slave (start/bin_in in, busy/done/ovf/dsp_data out)
// One add-3/shift iteration per cycle, BIN_W iterations, then a FORMAT cycle
// that publishes the result with optional leading-zero blanking (nibble F).
module bin2bcd_seq #(
  parameter int BIN_W    = 27,
  parameter int DIGITS   = 8,
  parameter int MAX_VAL  = 99_999_999,
  parameter int LZ_BLANK = 1
) (
  input logic          bcd_clk,
  input logic          bcd_rst,
  bin2bcd_seq_if.slave bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAX_BIN   = BIN_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FORMAT
  } state_t;

  state_t             state_reg;
  logic [BIN_W-1:0]   bin_reg;
  logic [BCD_W-1:0]   bcd_reg;
  logic [CNT_W-1:0]   iter_reg;
  logic               ovf_pending_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               ovf_reg;
  logic [BCD_W-1:0]   dsp_reg;

  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_fmt;
  // lead_zero[i]: digit i and every more-significant digit are zero
  logic [DIGITS-1:1]  lead_zero;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] digit;
      assign digit = bcd_reg[4*gi +: 4];

      // Per-nibble add-3, no carry into the next nibble
      assign bcd_adj[4*gi +: 4] = (digit >= 4'd5) ? digit + 4'd3 : digit;

      if (gi == 0) begin : g_lsd
        // Least-significant digit is always shown, so a value of 0 reads "0"
        assign bcd_fmt[3:0] = digit;
      end else begin : g_upper
        if (gi == DIGITS - 1) begin : g_msd
          assign lead_zero[gi] = (digit == 4'd0);
        end else begin : g_mid
          assign lead_zero[gi] = lead_zero[gi+1] && (digit == 4'd0);
        end
        assign bcd_fmt[4*gi +: 4] = ((LZ_BLANK != 0) && lead_zero[gi]) ? 4'hF : digit;
      end
    end
  endgenerate

  always_ff @(posedge bcd_clk) begin
    if (!bcd_rst) begin
      state_reg       <= IDLE;
      bin_reg         <= '0;
      bcd_reg         <= '0;
      iter_reg        <= '0;
      ovf_pending_reg <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      ovf_reg         <= 1'b0;
      dsp_reg         <= '1;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            bin_reg         <= bus.bin_in;
            bcd_reg         <= '0;
            iter_reg        <= '0;
            ovf_pending_reg <= (bus.bin_in > MAX_BIN);
            busy_reg        <= 1'b1;
            state_reg       <= SHIFT;
          end
        end
        SHIFT: begin
          // Adjusted accumulator and binary shift as one word; the bit
          // leaving the accumulator MSB is dropped.
          {bcd_reg, bin_reg} <= {bcd_adj, bin_reg} << 1;
          iter_reg           <= iter_reg + 1'b1;
          if (iter_reg == LAST_ITER) begin
            state_reg <= FORMAT;
          end
        end
        FORMAT: begin
          dsp_reg   <= ovf_pending_reg ? '1 : bcd_fmt;
          ovf_reg   <= ovf_pending_reg;
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.ovf      = ovf_reg;
  assign bus.dsp_data = dsp_reg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed bench for bin2bcd_seq. Two instances share the
// same stimulus: one with leading-zero blanking, one without. A cycle-level
// arithmetic model predicts busy/done/ovf/dsp_data and is compared on every
// falling edge; directed conversions also check literal results and latency.
module tb_bin2bcd_seq;
  localparam int BIN_W  = 27;
  localparam int DIGITS = 8;
  localparam int unsigned MAX_VAL = 99_999_999;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bin2bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) ifa ();
  bin2bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) ifb ();

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS), .MAX_VAL(MAX_VAL), .LZ_BLANK(1)) dut_a (
    .bcd_clk(clk), .bcd_rst(rst_n), .bus(ifa)
  );
  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS), .MAX_VAL(MAX_VAL), .LZ_BLANK(0)) dut_b (
    .bcd_clk(clk), .bcd_rst(rst_n), .bus(ifb)
  );

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Decimal digits by plain division, then blank leading zeros above digit 0.
  function automatic logic [31:0] model_dsp(input int unsigned v, input bit lz);
    logic [31:0] r;
    int unsigned p;
    bit lead;
    int unsigned d;
    r = '1;
    if (v > MAX_VAL) return r;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      p = 1;
      for (int j = 0; j < i; j++) p = p * 10;
      d = (v / p) % 10;
      if (lz && lead && d == 0 && i != 0) r[4*i +: 4] = 4'hF;
      else begin
        r[4*i +: 4] = d[3:0];
        lead = 1'b0;
      end
    end
    return r;
  endfunction

  // Cycle model: a request is taken only when idle; the result appears
  // BIN_W+1 edges after the accepting edge.
  logic        m_busy, m_done, m_ovf;
  int unsigned m_val;
  int          m_left;
  logic [31:0] m_dsp_a, m_dsp_b;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_ovf   <= 1'b0;
      m_left  <= 0;
      m_val   <= 0;
      m_dsp_a <= '1;
      m_dsp_b <= '1;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (ifa.start) begin
          m_busy <= 1'b1;
          m_val  <= int'(ifa.bin_in);
          m_left <= BIN_W + 1;
        end
      end else if (m_left == 1) begin
        m_busy  <= 1'b0;
        m_done  <= 1'b1;
        m_ovf   <= (m_val > MAX_VAL);
        m_dsp_a <= model_dsp(m_val, 1'b1);
        m_dsp_b <= model_dsp(m_val, 1'b0);
        m_left  <= 0;
      end else begin
        m_left <= m_left - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy_a", 32'(ifa.busy), 32'(m_busy));
      check("done_a", 32'(ifa.done), 32'(m_done));
      check("ovf_a", 32'(ifa.ovf), 32'(m_ovf));
      check("dsp_a", ifa.dsp_data, m_dsp_a);
      check("busy_b", 32'(ifb.busy), 32'(m_busy));
      check("done_b", 32'(ifb.done), 32'(m_done));
      check("dsp_b", ifb.dsp_data, m_dsp_b);
    end
  end

  task automatic set_in(input bit s, input int unsigned v);
    ifa.start  = s;
    ifa.bin_in = BIN_W'(v);
    ifb.start  = s;
    ifb.bin_in = BIN_W'(v);
  endtask

  task automatic wait_done(input string name, output bit ok);
    int i;
    ok = 1'b0;
    i = 0;
    while (!ok && i < 40) begin
      @(negedge clk);
      if (ifa.done === 1'b1) ok = 1'b1;
      i++;
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL %s timeout: done not seen within 40 cycles, expected within 28", name);
    end
  endtask

  task automatic convert(input string name, input int unsigned v,
                         input logic [31:0] ea, input logic [31:0] eb, input bit eo);
    int t0;
    bit ok;
    @(negedge clk);
    set_in(1'b1, v);
    @(negedge clk);
    t0 = cyc;
    set_in(1'b0, v);
    wait_done(name, ok);
    if (ok) begin
      check({name, " latency"}, 32'(cyc - t0), 32'd28);
      check({name, " dsp_blank"}, ifa.dsp_data, ea);
      check({name, " dsp_zeros"}, ifb.dsp_data, eb);
      check({name, " ovf"}, 32'(ifa.ovf), 32'(eo));
    end
    $display("txn %-10s in=%0d dsp_a=%h dsp_b=%h ovf=%b", name, v, ifa.dsp_data, ifb.dsp_data, ifa.ovf);
  endtask

  task automatic count_dones(input string name, input int cycles);
    int n;
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (ifa.done === 1'b1) n++;
    end
    check(name, 32'(n), 32'd0);
  endtask

  initial begin
    int t0;
    bit ok;
    set_in(1'b0, 0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle dsp", ifa.dsp_data, 32'hFFFF_FFFF);
    check("idle busy", 32'(ifa.busy), 32'd0);
    check("idle done", 32'(ifa.done), 32'd0);
    check("idle ovf", 32'(ifa.ovf), 32'd0);
    $display("txn reset     dsp_a=%h busy=%b", ifa.dsp_data, ifa.busy);

    // Pin the reference model against hand-computed words
    check("model 12345678", model_dsp(12_345_678, 1'b1), 32'h1234_5678);
    check("model 305 lz", model_dsp(305, 1'b1), 32'hFFFF_F305);
    check("model 0 lz", model_dsp(0, 1'b1), 32'hFFFF_FFF0);
    check("model 305 nolz", model_dsp(305, 1'b0), 32'h0000_0305);

    convert("12345678", 12_345_678, 32'h1234_5678, 32'h1234_5678, 1'b0);
    convert("305", 305, 32'hFFFF_F305, 32'h0000_0305, 1'b0);
    convert("zero", 0, 32'hFFFF_FFF0, 32'h0000_0000, 1'b0);
    convert("max", 99_999_999, 32'h9999_9999, 32'h9999_9999, 1'b0);
    convert("over", 100_000_000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    convert("42", 42, 32'hFFFF_FF42, 32'h0000_0042, 1'b0);

    // Start pulse while busy is ignored and bin_in is not resampled
    @(negedge clk);
    set_in(1'b1, 11);
    @(negedge clk);
    set_in(1'b0, 11);
    repeat (5) @(negedge clk);
    set_in(1'b1, 77);
    @(negedge clk);
    set_in(1'b0, 77);
    wait_done("busy pulse", ok);
    if (ok) check("busy pulse dsp", ifa.dsp_data, 32'hFFFF_FF11);
    count_dones("busy pulse extra done", 35);
    $display("txn busypulse dsp_a=%h", ifa.dsp_data);

    // Start held across the done cycle: next conversion begins right away
    @(negedge clk);
    set_in(1'b1, 11);
    @(negedge clk);
    set_in(1'b1, 77);
    wait_done("held first", ok);
    if (ok) check("held first dsp", ifa.dsp_data, 32'hFFFF_FF11);
    t0 = cyc;
    @(negedge clk);
    set_in(1'b0, 77);
    wait_done("held second", ok);
    if (ok) begin
      check("held second dsp", ifa.dsp_data, 32'hFFFF_FF77);
      check("held spacing", 32'(cyc - t0), 32'd29);
    end
    $display("txn held      dsp_a=%h", ifa.dsp_data);

    // Reset mid-conversion aborts without a done pulse
    @(negedge clk);
    set_in(1'b1, 555);
    @(negedge clk);
    set_in(1'b0, 555);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort dsp", ifa.dsp_data, 32'hFFFF_FFFF);
    check("abort busy", 32'(ifa.busy), 32'd0);
    count_dones("abort no done", 35);
    $display("txn abort     dsp_a=%h", ifa.dsp_data);
    convert("9", 9, 32'hFFFF_FFF9, 32'h0000_0009, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1);
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-packed-BCD converter ("shift-and-add-3" / double dabble) that produces the 32-bit `dsp_data` word consumed by the 8-digit multiplexed seven-segment driver.
- Sits directly upstream of that driver: counters, EEPROM readback or other sources hand it a binary value; it returns eight BCD nibbles, MSD in [31:28].
- Digits the driver cannot show (nibble 4'hF) are used deliberately for leading-zero blanking and overflow indication.

Parameters:
- BIN_W, 27, binary input width; conversion runs exactly BIN_W shift iterations.
- DIGITS, 8, number of BCD digits; output width = 4*DIGITS.
- MAX_VAL, 99_999_999, largest convertible value; anything above it is overflow.
- LZ_BLANK, 1, 1 = replace leading zero digits with 4'hF (least-significant digit never blanked); 0 = keep zeros.

Ports:
- `bcd_clk`, input, 1, system clock; all logic on its rising edge.
- `bcd_rst`, input, 1, synchronous active-low reset.
- `start`, input, 1, request conversion of `bin_in`; honoured only in IDLE.
- `bin_in`, input, BIN_W, binary value; sampled on the accepting edge only.
- `busy`, output, 1, conversion in progress.
- `done`, output, 1, one-cycle pulse; `dsp_data` and `ovf` are valid from this cycle.
- `ovf`, output, 1, last accepted value exceeded MAX_VAL; held until the next done.
- `dsp_data`, output, 4*DIGITS, packed BCD result, MSD in [31:28]; held between conversions.

Behaviour:
- Reset (`bcd_rst`=0 at a rising edge): state←IDLE; `busy`=0, `done`=0, `ovf`=0; `dsp_data`=all 4'hF (display blank); internal shift/BCD registers cleared.
- Reset mid-conversion aborts it: no `done` pulse, and `dsp_data` returns to all F.
- States: IDLE → SHIFT → FORMAT → IDLE.
- IDLE:
  - `start`=1 at edge k: latch `bin_in` into the shift register, clear the BCD accumulator, iteration counter←0.
  - Latch ovf_pending = (`bin_in` > MAX_VAL).
  - Go to SHIFT; `busy`=1 from edge k.
- SHIFT, one iteration per cycle:
  - Every BCD nibble ≥5 gets +3.
  - Then {bcd, bin} shifts left by 1, with the MSB of bin entering bcd[0].
  - After BIN_W iterations (edges k+1 … k+BIN_W) go to FORMAT.
- FORMAT, edge k+BIN_W+1:
  - If ovf_pending: `dsp_data`←all 4'hF and `ovf`←1.
  - Else: `dsp_data`←bcd with leading-zero blanking applied when LZ_BLANK=1, and `ovf`←0.
  - Blanking: scanning from the MSD, each zero digit becomes F until the first nonzero digit; digit 0 is never blanked, so a value of 0 gives …FFF0.
  - `done`=1 for exactly this cycle, `busy`←0, next state IDLE.
- Latency: start edge to `done`-high edge is BIN_W+1 cycles (28 by default). A new `start` is accepted on the cycle `done` is high, i.e. back-to-back conversions every BIN_W+2 cycles.
- `start` while `busy`=1 is ignored entirely: not queued, and `bin_in` is not resampled.
- `dsp_data` changes only at FORMAT or reset, so the downstream driver never sees intermediate BCD values.
- Width rules:
  - BCD accumulator is 4*DIGITS bits.
  - Add-3 is per nibble with no inter-nibble carry.
  - Bits shifted out of the accumulator MSB are discarded; this cannot happen for values ≤ MAX_VAL.
- Parameter constraint: MAX_VAL < 10^DIGITS and MAX_VAL < 2^BIN_W.

Test Plan:
- Reset then idle 5 cycles → `dsp_data`=32'hFFFF_FFFF, `busy`=0, `done`=0, `ovf`=0.
- `start` with `bin_in`=12_345_678 → `done` exactly 28 cycles after the start edge, `dsp_data`=32'h1234_5678, `ovf`=0, `busy` high throughout and low with `done`.
- LZ_BLANK=1: `bin_in`=305 → 32'hFFFF_F305; `bin_in`=0 → 32'hFFFF_FFF0. LZ_BLANK=0: `bin_in`=305 → 32'h0000_0305.
- Boundaries:
  - 99_999_999 → 32'h9999_9999 with `ovf`=0.
  - 100_000_000 → 32'hFFFF_FFFF with `ovf`=1.
  - Then 42 → 32'hFFFF_FF42 with `ovf`=0.
- Pulse `start` with 77 while busy on 11 → single `done`, result 32'hFFFF_FF11. `start` held high across the `done` cycle with 77 → second conversion starts immediately and gives 32'hFFFF_FF77 28 cycles later.
- Assert `bcd_rst`=0 at iteration 10 of a conversion of 555 → no `done`, `dsp_data`=all F. After release, a conversion of 9 → 32'hFFFF_FFF9.
